// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
//   REG_ADDR_W / REG_DATA_W : default register index / data widths
//   REG_ZERO                : hard-wired zero register index, never written
//   wr_req_t                : write request {valid, idx, data} at default widths
//   arb_state_e             : arbiter grant state
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [0:0] {
    A_PRI   = 1'b0,
    B_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_starvation_guard.sv
// Starvation guard for requester B: counts consecutive cycles in which B loses to A and
// forces a single B grant once MAX_WAIT losses have accumulated.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   a_valid_i : requester A has a write pending
//   b_valid_i : requester B has a write pending
//   force_b_o : high for the one cycle in which B is granted unconditionally
module regfile_write_arbiter_starvation_guard
  import regfile_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic force_b_o
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  arb_state_e       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      A_PRI: begin
        if (a_valid_i && b_valid_i) begin
          // This cycle is another B loss; the MAX_WAIT-th loss arms the forced grant.
          if (wait_q == WaitW'(MAX_WAIT - 1)) begin
            state_d = B_FORCE;
            wait_d  = WaitW'(MAX_WAIT);
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          // Either B transferred (A idle) or B is not asking: the loss streak ends.
          wait_d = '0;
        end
      end
      B_FORCE: begin
        // One forced cycle only, whether or not B actually still held valid.
        state_d = A_PRI;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_PRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign force_b_o = (state_q == B_FORCE);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the writeback stage (A, fixed
// priority) and the mul/div result return (B, protected by a starvation guard).
// The granted request is registered one cycle and drives the register file directly.
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   a_valid/a_ready         : A handshake; a_reg/a_data A payload
//   b_valid/b_ready         : B handshake; b_reg/b_data B payload
//   regWrite/WriteRegister/
//   WriteData               : registered register-file write port
//   b_forced                : B is granted by the starvation guard this cycle
//   b_stall_cnt             : saturating count of cycles with B waiting
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = REG_DATA_W,
  parameter int unsigned ADDR_W      = REG_ADDR_W,
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_reg,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_reg,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [DATA_W-1:0]      WriteData,
  output logic                   b_forced,
  output logic [STALL_CNT_W-1:0] b_stall_cnt
);

  // Request bundle at this instance's widths.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } req_t;

  logic force_b;
  logic a_fire, b_fire;
  req_t sel;

  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  regfile_write_arbiter_starvation_guard #(
    .MAX_WAIT (MAX_WAIT)
  ) u_guard (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .force_b_o (force_b)
  );

  // Grants depend only on guard state and the other side's valid, never on own valid.
  assign a_ready  = !force_b;
  assign b_ready  = force_b || !a_valid;
  assign b_forced = force_b;

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  always_comb begin
    sel.valid = a_fire || b_fire;
    sel.idx   = b_fire ? b_reg  : a_reg;
    sel.data  = b_fire ? b_data : a_data;
  end

  always_comb begin
    we_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    stall_d = stall_q;
    if (sel.valid) begin
      // A register-0 write still completes its handshake but is never issued.
      we_d   = (sel.idx != ADDR_W'(REG_ZERO));
      idx_d  = sel.idx;
      data_d = sel.data;
    end
    if (b_valid && !b_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= we_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign regWrite      = we_q;
  assign WriteRegister = idx_q;
  assign WriteData     = data_q;
  assign b_stall_cnt   = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned MW = 4;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          regWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          b_forced;
  logic [SW-1:0] b_stall_cnt;

  regfile_write_arbiter #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .MAX_WAIT    (MW),
    .STALL_CNT_W (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_reg         (a_reg),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_reg         (b_reg),
    .b_data        (b_data),
    .regWrite      (regWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .b_forced      (b_forced),
    .b_stall_cnt   (b_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t  q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";
  logic [DW-1:0] ad, bd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
    end
  endtask

  // Drive one cycle of requests, check the grants, and queue the writes that must
  // appear on the register-file port after the coming edge. Entered and left at posedge+1.
  task automatic step(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] adt,
                      input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bdt,
                      input logic e_ar, input logic e_br, input logic e_f);
    exp_t e;
    a_valid = av; a_reg = ar; a_data = adt;
    b_valid = bv; b_reg = br; b_data = bdt;
    @(negedge clk);
    chk("a_ready", a_ready, e_ar);
    chk("b_ready", b_ready, e_br);
    chk("b_forced", b_forced, e_f);
    if (av && e_ar && ar != '0) begin
      e.r = ar; e.d = adt; e.c = cyc + 1; q.push_back(e);
    end
    if (bv && e_br && br != '0) begin
      e.r = br; e.d = bdt; e.c = cyc + 1; q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every issued write must match the oldest queued expectation, one cycle late.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      chk("one_grant", a_valid && b_valid && a_ready && b_ready, 1'b0);
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        chk("regWrite", regWrite, 1'b1);
        chk("WriteRegister", WriteRegister, e.r);
        chk("WriteData", WriteData, e.d);
      end else if (regWrite) begin
        chk("spurious_regWrite", regWrite, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    #1;
    chk("rst_regWrite", regWrite, 1'b0);
    chk("rst_WriteRegister", WriteRegister, 0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_stall", b_stall_cnt, 0);
    chk("rst_forced", b_forced, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    phase = "b_only";
    step(0, 0, 0, 1, 9, 32'h0000_000F, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);

    phase = "both_valid";
    for (int k = 0; k < 4; k++) step(1, 1, 32'(2 + k), 1, 2, 32'hB, 1, 0, 0);
    step(1, 1, 32'h6, 1, 2, 32'hB, 0, 1, 1);
    step(1, 1, 32'h6, 0, 0, 0, 1, 0, 0);
    chk("stall_cnt", b_stall_cnt, 4);

    phase = "reg0";
    step(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0);
    chk("r0_regWrite", regWrite, 1'b0);
    chk("r0_WriteRegister", WriteRegister, 0);
    chk("r0_WriteData", WriteData, 32'hDEAD_BEEF);
    step(1, 3, 32'h5, 0, 0, 0, 1, 0, 0);

    phase = "b_drop";
    for (int k = 0; k < 4; k++) step(1, 4, 32'(16 + k), 1, 5, 32'h55, 1, 0, 0);
    step(1, 4, 32'h14, 0, 5, 32'h55, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 4, 32'(20 + k), 1, 5, 32'h55, 1, 0, 0);
    step(1, 4, 32'h18, 1, 5, 32'h55, 0, 1, 1);
    step(1, 4, 32'h18, 0, 0, 0, 1, 0, 0);
    chk("stall_cnt", b_stall_cnt, 12);

    phase = "mid_reset";
    step(1, 7, 32'h77, 1, 8, 32'h88, 1, 0, 0);
    #2;
    chk("pre_regWrite", regWrite, 1'b1);
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("async_regWrite", regWrite, 1'b0);
    chk("async_WriteRegister", WriteRegister, 0);
    chk("async_WriteData", WriteData, 0);
    chk("async_stall", b_stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) step(1, 10, 32'(160 + k), 1, 11, 32'hBB, 1, 0, 0);
    step(1, 10, 32'hA4, 1, 11, 32'hBB, 0, 1, 1);
    step(1, 10, 32'hA4, 0, 0, 0, 1, 0, 0);
    chk("stall_cnt", b_stall_cnt, 4);

    phase = "saturate";
    ad = 32'h100;
    bd = 32'h200;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(1, 12, ad, 1, 13, bd, 1, 0, 0);
        ad = ad + 1;
      end
      step(1, 12, ad, 1, 13, bd, 0, 1, 1);
      bd = bd + 1;
      if (r == 1) chk("stall_cnt_mid", b_stall_cnt, 12);
    end
    chk("stall_cnt_sat", b_stall_cnt, 15);

    phase = "drain";
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("queue_empty", 64'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
